shift_add_multiplier_datapath: RTL and testbench

- Datapath of an N-bit unsigned sequential shift-and-add multiplier.
- Holds an accumulator A (N bits), a multiplier/low-product register Q (N bits), a latched multiplicand M (N bits) and a carry bit C.
- An external controller pulses do_init once, then asserts do_shift for exactly N clock cycles; afterwards product = multiplicand * multiplier.
- The block contains no sequencing logic of its own; the controller supplies all sequencing.

---
 rtl/shift_add_multiplier_datapath.sv | 45 ++++
 tb/tb_shift_add_multiplier_datapath.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier_datapath.sv
// Datapath of an N-bit unsigned shift-and-add multiplier.
// An external controller pulses do_init, then issues N do_shift steps.
module shift_add_multiplier_datapath #(
  parameter int N = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             do_init,
  input  logic             do_shift,
  input  logic [N-1:0]     multiplicand,
  input  logic [N-1:0]     multiplier,
  output logic [2*N-1:0]   product
);

  logic [N-1:0] a;
  logic [N-1:0] q;
  logic [N-1:0] m;
  logic [N:0]   sum;

  // sum[N] is the carry C; it becomes the MSB of A on the shift.
  always_comb begin
    sum = {1'b0, a};
    if (q[0]) begin
      sum = {1'b0, a} + {1'b0, m};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a <= '0;
      q <= '0;
      m <= '0;
    end else if (do_init) begin
      a <= '0;
      q <= multiplier;
      m <= multiplicand;
    end else if (do_shift) begin
      a <= sum[N:1];
      q <= {sum[0], q[N-1:1]};
    end
  end

  assign product = {a, q};

endmodule

// File: tb/tb_shift_add_multiplier_datapath.sv
// Self-checking bench: directed vector table plus randomized operations
// compared against an arithmetic model of the partial product.
module tb_shift_add_multiplier_datapath;

  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic           do_init;
  logic           do_shift;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [2*N-1:0] product;

  int total = 0;
  int bad   = 0;

  shift_add_multiplier_datapath #(.N(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .do_init      (do_init),
    .do_shift     (do_shift),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic           rst;
    logic           ini;
    logic           sh;
    logic [N-1:0]   mc;
    logic [N-1:0]   mp;
    logic [2*N-1:0] exp;
    string          nm;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic i, input logic s,
                              input logic [N-1:0] mc, input logic [N-1:0] mp,
                              input logic [2*N-1:0] e, input string nm);
    vec_t v;
    v.rst = r; v.ini = i; v.sh = s; v.mc = mc; v.mp = mp; v.exp = e; v.nm = nm;
    vecs.push_back(v);
  endfunction

  task automatic apply(input logic r, input logic i, input logic s,
                       input logic [N-1:0] mc, input logic [N-1:0] mp);
    reset = r; do_init = i; do_shift = s; multiplicand = mc; multiplier = mp;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [2*N-1:0] act,
                       input logic [2*N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: product=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // After k shifts from init(mc, mp): the low k multiplier bits have been
  // consumed into a partial product sitting k places below the top.
  function automatic logic [2*N-1:0] model(input logic [N-1:0] mc,
                                           input logic [N-1:0] mp, input int k);
    longint unsigned lo, part, res;
    lo   = longint'(mp) % (64'd1 << k);
    part = (longint'(mc) * lo) << (N - k);
    res  = part + (longint'(mp) >> k);
    return res[2*N-1:0];
  endfunction

  logic [N-1:0] mcl, mpl;
  int           k;

  initial begin
    reset = 1'b0; do_init = 1'b0; do_shift = 1'b0;
    multiplicand = '0; multiplier = '0;

    // reset / idle
    add(1, 0, 0, 0,  0,  8'h00, "reset");
    add(0, 0, 0, 0,  0,  8'h00, "idle_after_reset");
    add(0, 0, 1, 5,  9,  8'h00, "shift_no_init");
    // 11 * 6
    add(0, 1, 0, 11, 6,  8'h06, "basic_init");
    add(0, 0, 0, 2,  3,  8'h06, "basic_idle0");
    add(0, 0, 1, 11, 6,  8'h03, "basic_s1");
    add(0, 0, 0, 11, 6,  8'h03, "basic_idle1");
    add(0, 0, 1, 11, 6,  8'h59, "basic_s2");
    add(0, 0, 1, 11, 6,  8'h84, "basic_s3_carry");
    add(0, 0, 1, 11, 6,  8'h42, "basic_s4");
    add(0, 0, 0, 11, 6,  8'h42, "basic_hold");
    add(0, 0, 1, 11, 6,  8'h21, "extra_shift");
    // 15 * 15
    add(0, 1, 0, 15, 15, 8'h0F, "max_init");
    add(0, 0, 1, 15, 15, 8'h7F, "max_s1");
    add(0, 0, 1, 15, 15, 8'hB7, "max_s2");
    add(0, 0, 1, 15, 15, 8'hD3, "max_s3");
    add(0, 0, 1, 15, 15, 8'hE1, "max_s4");
    // inputs change after init: 3 * 5
    add(0, 1, 0, 3,  5,  8'h05, "chg_init");
    add(0, 0, 1, 15, 15, 8'h1A, "chg_s1");
    add(0, 0, 1, 15, 15, 8'h0D, "chg_s2");
    add(0, 0, 1, 15, 15, 8'h1E, "chg_s3");
    add(0, 0, 1, 15, 15, 8'h0F, "chg_s4");
    // priority
    add(0, 1, 1, 2,  9,  8'h09, "init_over_shift");
    add(0, 0, 1, 2,  9,  8'h14, "prio_s1");
    add(0, 0, 1, 2,  9,  8'h0A, "prio_s2");
    add(1, 1, 1, 7,  7,  8'h00, "reset_over_init");
    add(0, 0, 0, 7,  7,  8'h00, "reset_abort_hold");
    // zero operands
    add(0, 1, 0, 0,  13, 8'h0D, "zmc_init");
    add(0, 0, 1, 0,  13, 8'h06, "zmc_s1");
    add(0, 0, 1, 0,  13, 8'h03, "zmc_s2");
    add(0, 0, 1, 0,  13, 8'h01, "zmc_s3");
    add(0, 0, 1, 0,  13, 8'h00, "zmc_s4");
    add(0, 1, 0, 13, 0,  8'h00, "zmp_init");
    add(0, 0, 1, 13, 0,  8'h00, "zmp_s1");
    add(0, 0, 1, 13, 0,  8'h00, "zmp_s2");
    add(0, 0, 1, 13, 0,  8'h00, "zmp_s3");
    add(0, 0, 1, 13, 0,  8'h00, "zmp_s4");

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].ini, vecs[i].sh, vecs[i].mc, vecs[i].mp);
      check(vecs[i].nm, product, vecs[i].exp);
    end

    // Randomized operations; model tracks latched operands and shift count.
    apply(1, 0, 0, '0, '0);
    mcl = '0; mpl = '0; k = 0;
    for (int it = 0; it < 400; it++) begin
      logic r, ini, sh;
      logic [N-1:0] a, b;
      int sel;
      sel = int'($urandom_range(0, 9));
      r   = ($urandom_range(0, 49) == 0);
      ini = (sel < 2);
      sh  = ((sel >= 2 && sel < 8) || (sel == 1)) && (k < N);
      a   = N'($urandom);
      b   = N'($urandom);
      apply(r, ini, sh, a, b);
      if (r) begin
        mcl = '0; mpl = '0; k = 0;
      end else if (ini) begin
        mcl = a; mpl = b; k = 0;
      end else if (sh) begin
        k++;
      end
      check("random", product, model(mcl, mpl, k));
    end

    // Full multiplications of random operands, checked only at the end.
    for (int it = 0; it < 40; it++) begin
      logic [N-1:0] a, b;
      logic [2*N-1:0] full;
      a = N'($urandom);
      b = N'($urandom);
      apply(0, 1, 0, a, b);
      for (int s = 0; s < N; s++) apply(0, 0, 1, N'($urandom), N'($urandom));
      full = (2*N)'(a) * (2*N)'(b);
      check("random_full", product, full);
    end

    reset = 1'b0; do_init = 1'b0; do_shift = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
